// File: rtl/row_seq_pkg.sv
// rtl/row_seq_pkg.sv - shared encodings for the paired-row sequencer
package row_seq_pkg;

    // Mode encodings as seen on the mode input
    localparam logic [1:0] M_SINGLE = 2'd0;
    localparam logic [1:0] M_SCAN   = 2'd1;
    localparam logic [1:0] M_ALL    = 2'd2;

    // Sequencer state encodings
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        MODE_SINGLE = M_SINGLE,
        MODE_SCAN   = M_SCAN,
        MODE_ALL    = M_ALL
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_DRIVE = S_DRIVE,
        ST_GAP   = S_GAP,
        ST_DONE  = S_DONE
    } state_t;

    // The reserved encoding behaves exactly like SINGLE, so fold it at latch time
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return ((m == M_SCAN) || (m == M_ALL)) ? m : M_SINGLE;
    endfunction

endpackage

// File: rtl/row_onehot_dec.sv
// rtl/row_onehot_dec.sv - row index to one-hot line decoder with all-ones override
module row_onehot_dec #(
    parameter int PAIR_ROW_NO = 64,
    parameter int IDX_W       = $clog2(PAIR_ROW_NO)
) (
    input  logic [IDX_W-1:0]       i_idx,
    input  logic                   i_all,
    output logic [PAIR_ROW_NO-1:0] o_onehot
);

    localparam logic [PAIR_ROW_NO-1:0] ONE = PAIR_ROW_NO'(1);

    // Select a single line, or every line when broadcasting to all rows
    always_comb begin
        o_onehot = ONE << i_idx;
        if (i_all) begin
            o_onehot = '1;
        end
    end

endmodule

// File: rtl/row_seq.sv
// rtl/row_seq.sv - paired-row sequencer driving row0/row1 line pairs
module row_seq
    import row_seq_pkg::*;
#(
    parameter int PAIR_ROW_NO  = 64,
    parameter int PULSE_W_BITS = 8,
    parameter int GAP_CYC      = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic [1:0]                     mode,
    input  logic [$clog2(PAIR_ROW_NO)-1:0] row_first,
    input  logic [$clog2(PAIR_ROW_NO)-1:0] row_last,
    input  logic [PULSE_W_BITS-1:0]        pulse_len,
    output logic [PAIR_ROW_NO-1:0]         row0,
    output logic [PAIR_ROW_NO-1:0]         row1,
    output logic [$clog2(PAIR_ROW_NO)-1:0] row_idx,
    output logic                           row_strobe,
    output logic                           busy,
    output logic                           done
);

    localparam int IDX_W = $clog2(PAIR_ROW_NO);
    // The shared counter holds "remaining cycles minus one" for both pulse and gap
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int CNT_W = (PULSE_W_BITS > GAP_W) ? PULSE_W_BITS : GAP_W;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    logic [1:0]              r_state;
    logic [1:0]              r_mode;
    logic [IDX_W-1:0]        r_row_last;
    logic [PULSE_W_BITS-1:0] r_plen;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_row_idx;
    logic [PAIR_ROW_NO-1:0]  r_row0;
    logic                    r_drive;
    logic                    r_strobe;
    logic                    r_busy;
    logic                    r_done;

    logic [PULSE_W_BITS-1:0] w_pulse_in;
    logic [CNT_W-1:0]        w_pulse_start;
    logic [CNT_W-1:0]        w_pulse_reload;
    logic                    w_last_row;
    logic                    w_cnt_zero;
    logic [IDX_W-1:0]        w_next_idx;
    logic [IDX_W-1:0]        w_dec_idx;
    logic                    w_dec_all;
    logic [PAIR_ROW_NO-1:0]  w_dec_lines;

    // A zero pulse length still drives each row for one cycle
    assign w_pulse_in     = (pulse_len == '0) ? PULSE_W_BITS'(1) : pulse_len;
    assign w_pulse_start  = CNT_W'(w_pulse_in - PULSE_W_BITS'(1));
    assign w_pulse_reload = CNT_W'(r_plen - PULSE_W_BITS'(1));
    assign w_cnt_zero     = (r_cnt == '0);
    assign w_next_idx     = r_row_idx + IDX_W'(1);
    // Only SCAN has more than one row; power-of-two row count makes the +1 wrap for free
    assign w_last_row     = (r_mode != M_SCAN) || (r_row_idx == r_row_last);

    // In IDLE the decoder looks at the incoming request, otherwise at the next scan row
    assign w_dec_idx = (r_state == S_IDLE) ? row_first : w_next_idx;
    assign w_dec_all = (r_state == S_IDLE) ? (norm_mode(mode) == M_ALL) : (r_mode == M_ALL);

    row_onehot_dec #(
        .PAIR_ROW_NO (PAIR_ROW_NO),
        .IDX_W       (IDX_W)
    ) u_dec (
        .i_idx    (w_dec_idx),
        .i_all    (w_dec_all),
        .o_onehot (w_dec_lines)
    );

    // Sequencer FSM with the shared pulse/gap down-counter and registered line drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mode     <= M_SINGLE;
            r_row_last <= '0;
            r_plen     <= PULSE_W_BITS'(1);
            r_cnt      <= '0;
            r_row_idx  <= '0;
            r_row0     <= '0;
            r_drive    <= 1'b0;
            r_strobe   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            if ((r_state != S_IDLE) && abort) begin
                r_state <= S_IDLE;
                r_row0  <= '0;
                r_drive <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            r_mode     <= norm_mode(mode);
                            r_row_last <= row_last;
                            r_plen     <= w_pulse_in;
                            r_cnt      <= w_pulse_start;
                            r_row_idx  <= row_first;
                            r_row0     <= w_dec_lines;
                            r_drive    <= 1'b1;
                            r_strobe   <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= S_DRIVE;
                        end
                    end
                    S_DRIVE: begin
                        if (!w_cnt_zero) begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end else if (w_last_row) begin
                            r_state <= S_DONE;
                            r_row0  <= '0;
                            r_drive <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (GAP_CYC == 0) begin
                            r_row_idx <= w_next_idx;
                            r_row0    <= w_dec_lines;
                            r_strobe  <= 1'b1;
                            r_cnt     <= w_pulse_reload;
                        end else begin
                            r_state <= S_GAP;
                            r_row0  <= '0;
                            r_drive <= 1'b0;
                            r_cnt   <= GAP_LOAD;
                        end
                    end
                    S_GAP: begin
                        if (!w_cnt_zero) begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end else begin
                            r_state   <= S_DRIVE;
                            r_row_idx <= w_next_idx;
                            r_row0    <= w_dec_lines;
                            r_drive   <= 1'b1;
                            r_strobe  <= 1'b1;
                            r_cnt     <= w_pulse_reload;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // row1 is the complement of the registered row0, gated by the registered drive flag
    assign row1       = r_drive ? ~r_row0 : '0;
    assign row0       = r_row0;
    assign row_idx    = r_row_idx;
    assign row_strobe = r_strobe;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_row_seq.sv
// tb/tb_row_seq.sv - self-checking bench for row_seq
module tb_row_seq;

    localparam int NR  = 64;
    localparam int PW  = 8;
    localparam int GAP = 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [1:0]    mode;
    logic [5:0]    row_first;
    logic [5:0]    row_last;
    logic [PW-1:0] pulse_len;
    logic [NR-1:0] row0;
    logic [NR-1:0] row1;
    logic [5:0]    row_idx;
    logic          row_strobe;
    logic          busy;
    logic          done;

    row_seq #(
        .PAIR_ROW_NO  (NR),
        .PULSE_W_BITS (PW),
        .GAP_CYC      (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .row_first  (row_first),
        .row_last   (row_last),
        .pulse_len  (pulse_len),
        .row0       (row0),
        .row1       (row1),
        .row_idx    (row_idx),
        .row_strobe (row_strobe),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic [NR-1:0] row0;
        logic [NR-1:0] row1;
        logic [5:0]    idx;
        logic          chk_idx;
        logic          strobe;
        logic          busy;
        logic          done;
    } exp_t;

    exp_t q[$];
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   busy_cnt = 0;
    int   strb_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected per-cycle trace from the row list, pulse length and gap length
    task automatic push_seq(input logic [1:0] m, input int first, input int last, input int plen);
        int   rows[$];
        int   pl;
        int   r;
        exp_t e;
        pl = (plen == 0) ? 1 : plen;
        if (m == 2'd1) begin
            r = first;
            forever begin
                rows.push_back(r);
                if (r == last) break;
                r = (r + 1) % NR;
            end
        end else begin
            rows.push_back(first);
        end
        for (int i = 0; i < rows.size(); i++) begin
            for (int c = 0; c < pl; c++) begin
                e.row0    = (m == 2'd2) ? {NR{1'b1}} : (64'd1 << rows[i]);
                e.row1    = ~e.row0;
                e.idx     = 6'(rows[i]);
                e.chk_idx = 1'b1;
                e.strobe  = (c == 0);
                e.busy    = 1'b1;
                e.done    = 1'b0;
                q.push_back(e);
            end
            if (i != rows.size() - 1) begin
                for (int g = 0; g < GAP; g++) begin
                    e.row0 = '0; e.row1 = '0; e.idx = '0; e.chk_idx = 1'b0;
                    e.strobe = 1'b0; e.busy = 1'b1; e.done = 1'b0;
                    q.push_back(e);
                end
            end
        end
        e.row0 = '0; e.row1 = '0; e.idx = '0; e.chk_idx = 1'b0;
        e.strobe = 1'b0; e.busy = 1'b1; e.done = 1'b1;
        q.push_back(e);
    endtask

    // Compare every cycle against the expected trace, or against idle when none is pending
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (busy) busy_cnt++;
            if (row_strobe) strb_cnt++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("row0", row0, e.row0);
                chk("row1", row1, e.row1);
                chk("strobe", {63'd0, row_strobe}, {63'd0, e.strobe});
                chk("busy", {63'd0, busy}, {63'd0, e.busy});
                chk("done", {63'd0, done}, {63'd0, e.done});
                if (e.chk_idx) chk("row_idx", {58'd0, row_idx}, {58'd0, e.idx});
            end else begin
                chk("idle_row0", row0, 64'd0);
                chk("idle_row1", row1, 64'd0);
                chk("idle_strobe", {63'd0, row_strobe}, 64'd0);
                chk("idle_busy", {63'd0, busy}, 64'd0);
                chk("idle_done", {63'd0, done}, 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a clock edge with the DUT idle; returns one step after the accept edge
    task automatic do_start(input logic [1:0] m, input int f, input int l, input int p);
        mode      = m;
        row_first = 6'(f);
        row_last  = 6'(l);
        pulse_len = PW'(p);
        start     = 1'b1;
        busy_cnt  = 0;
        strb_cnt  = 0;
        @(posedge clk);
        push_seq(m, f, l, p);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() > 0 && n < 3000) begin
            tick();
            n++;
        end
        chk("timeout", 64'(q.size()), 64'd0);
        q.delete();
    endtask

    initial begin
        exp_t keep;
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0;
        row_first = '0; row_last = '0; pulse_len = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_row0", row0, 64'd0);
        chk("reset_row1", row1, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_idx", {58'd0, row_idx}, 64'd0);
        rst = 1'b0;
        tick();

        // SINGLE row 5, pulse 3
        do_start(2'd0, 5, 0, 3);
        chk("single_row0", row0, 64'h0000_0000_0000_0020);
        chk("single_row1", row1, 64'hFFFF_FFFF_FFFF_FFDF);
        wait_done();
        chk("single_busy_cycles", 64'(busy_cnt), 64'd4);
        chk("single_strobes", 64'(strb_cnt), 64'd1);

        // Back-to-back wrapping SCAN 62..1, pulse 2
        do_start(2'd1, 62, 1, 2);
        chk("wrap_first_row0", row0, 64'h4000_0000_0000_0000);
        wait_done();
        chk("wrap_busy_cycles", 64'(busy_cnt), 64'd15);
        chk("wrap_strobes", 64'(strb_cnt), 64'd4);

        // ALL with pulse 0
        do_start(2'd2, 7, 0, 0);
        chk("all_row0", row0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("all_row1", row1, 64'd0);
        wait_done();
        chk("all_busy_cycles", 64'(busy_cnt), 64'd2);

        // Reserved mode acts as SINGLE
        do_start(2'd3, 9, 20, 2);
        wait_done();
        chk("rsvd_busy_cycles", 64'(busy_cnt), 64'd3);

        // Abort during the gap after row 3 of SCAN 0..7
        do_start(2'd1, 0, 7, 2);
        repeat (14) tick();
        chk("abort_in_gap_row0", row0, 64'd0);
        chk("abort_in_gap_busy", {63'd0, busy}, 64'd1);
        abort = 1'b1;
        keep = q[0];
        q.delete();
        q.push_back(keep);
        tick();
        abort = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        do_start(2'd0, 33, 0, 1);
        chk("post_abort_row0", row0, 64'h0000_0002_0000_0000);
        wait_done();

        // Start while busy is ignored, row_first changes have no effect
        do_start(2'd1, 10, 13, 3);
        repeat (5) tick();
        start = 1'b1; mode = 2'd2; row_first = 6'd40;
        repeat (3) tick();
        start = 1'b0; row_first = 6'd0;
        wait_done();
        chk("busy_start_strobes", 64'(strb_cnt), 64'd4);
        chk("busy_start_cycles", 64'(busy_cnt), 64'd19);

        // Asynchronous reset mid-DRIVE of a SCAN
        do_start(2'd1, 0, 7, 4);
        tick();
        #3;
        rst = 1'b1;
        #1;
        q.delete();
        chk("arst_row0", row0, 64'd0);
        chk("arst_row1", row1, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_strobe", {63'd0, row_strobe}, 64'd0);
        chk("arst_idx", {58'd0, row_idx}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        do_start(2'd0, 2, 0, 1);
        chk("post_rst_row0", row0, 64'h0000_0000_0000_0004);
        wait_done();
        chk("post_rst_busy_cycles", 64'(busy_cnt), 64'd2);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
